// File: rtl/universal_register.sv
// ============================================================================
// Module      : universal_register
// Description : WIDTH-bit register with per-cycle hold/load/shift/rotate/
//               increment/decrement mode select and a counter wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module universal_register #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    output logic [WIDTH-1:0] out,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             zero,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_RESET_VAL = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] c_ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] c_ALL_ZERO  = '0;

    localparam logic [2:0] c_MODE_HOLD = 3'b000;
    localparam logic [2:0] c_MODE_LOAD = 3'b001;
    localparam logic [2:0] c_MODE_SHL  = 3'b010;
    localparam logic [2:0] c_MODE_SHR  = 3'b011;
    localparam logic [2:0] c_MODE_ROL  = 3'b100;
    localparam logic [2:0] c_MODE_ROR  = 3'b101;
    localparam logic [2:0] c_MODE_INC  = 3'b110;
    localparam logic [2:0] c_MODE_DEC  = 3'b111;

    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    always_comb begin
        w_next = out;
        w_wrap = 1'b0;
        case (mode)
            c_MODE_HOLD: w_next = out;
            c_MODE_LOAD: w_next = d;
            c_MODE_SHL:  w_next = {out[WIDTH-2:0], sin_lsb};
            c_MODE_SHR:  w_next = {sin_msb, out[WIDTH-1:1]};
            c_MODE_ROL:  w_next = {out[WIDTH-2:0], out[WIDTH-1]};
            c_MODE_ROR:  w_next = {out[0], out[WIDTH-1:1]};
            c_MODE_INC: begin
                w_next = out + c_ONE;
                w_wrap = (out == c_ALL_ONES);
            end
            c_MODE_DEC: begin
                w_next = out - c_ONE;
                w_wrap = (out == c_ALL_ZERO);
            end
            default: begin
                w_next = out;
                w_wrap = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out  <= c_RESET_VAL;
            wrap <= 1'b0;
        end else begin
            out  <= w_next;
            wrap <= w_wrap;
        end
    end

    assign sout_msb = out[WIDTH-1];
    assign sout_lsb = out[0];
    assign zero     = (out == c_ALL_ZERO);

endmodule

`default_nettype wire

// File: tb/tb_universal_register.sv
// ============================================================================
// Module      : tb_universal_register
// Description : Vector-table and randomized reference-model bench for
//               universal_register (WIDTH=4, RESET_VAL=4'b1010).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_universal_register;

    localparam int unsigned   WIDTH   = 4;
    localparam logic [3:0]    c_RVAL  = 4'b1010;

    localparam logic [2:0] c_HOLD = 3'b000;
    localparam logic [2:0] c_LOAD = 3'b001;
    localparam logic [2:0] c_SHL  = 3'b010;
    localparam logic [2:0] c_SHR  = 3'b011;
    localparam logic [2:0] c_ROL  = 3'b100;
    localparam logic [2:0] c_ROR  = 3'b101;
    localparam logic [2:0] c_INC  = 3'b110;
    localparam logic [2:0] c_DEC  = 3'b111;

    logic             clk;
    logic             rst;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_lsb;
    logic             sin_msb;
    logic [WIDTH-1:0] out;
    logic             sout_msb;
    logic             sout_lsb;
    logic             zero;
    logic             wrap;

    int vectors;
    int miscompares;

    universal_register #(
        .WIDTH     (WIDTH),
        .RESET_VAL (32'(c_RVAL))
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .d        (d),
        .sin_lsb  (sin_lsb),
        .sin_msb  (sin_msb),
        .out      (out),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .zero     (zero),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [2:0] mode;
        logic [3:0] d;
        logic       sl;
        logic       sm;
        logic [3:0] exp_out;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [3:0] eo, input logic ew);
        check({name, ".out"},      32'(out),      32'(eo));
        check({name, ".wrap"},     32'(wrap),     32'(ew));
        check({name, ".zero"},     32'(zero),     32'(eo == 4'd0));
        check({name, ".sout_msb"}, 32'(sout_msb), 32'(eo[3]));
        check({name, ".sout_lsb"}, 32'(sout_lsb), 32'(eo[0]));
    endtask

    // Inputs change 1 time unit after the rising edge; results are sampled there too.
    task automatic apply(input logic [2:0] m, input logic [3:0] dv, input logic sl, input logic sm);
        mode    = m;
        d       = dv;
        sin_lsb = sl;
        sin_msb = sm;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          m;
        int          nm;
        logic        mw;
        logic [2:0]  rmode;
        logic [3:0]  rd;
        logic        rsl;
        logic        rsm;

        vectors     = 0;
        miscompares = 0;

        vecs[0]  = '{c_LOAD, 4'b0110, 1'b0, 1'b0, 4'b0110, 1'b0};
        vecs[1]  = '{c_HOLD, 4'b1111, 1'b1, 1'b1, 4'b0110, 1'b0};
        vecs[2]  = '{c_HOLD, 4'b1111, 1'b0, 1'b1, 4'b0110, 1'b0};
        vecs[3]  = '{c_HOLD, 4'b1111, 1'b1, 1'b0, 4'b0110, 1'b0};
        vecs[4]  = '{c_SHL,  4'b0000, 1'b1, 1'b0, 4'b1101, 1'b0};
        vecs[5]  = '{c_SHR,  4'b0000, 1'b1, 1'b0, 4'b0110, 1'b0};
        vecs[6]  = '{c_SHR,  4'b0000, 1'b0, 1'b1, 4'b1011, 1'b0};
        vecs[7]  = '{c_LOAD, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0};
        vecs[8]  = '{c_ROL,  4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0};
        vecs[9]  = '{c_ROR,  4'b0000, 1'b0, 1'b1, 4'b1000, 1'b0};
        vecs[10] = '{c_LOAD, 4'b0011, 1'b0, 1'b0, 4'b0011, 1'b0};
        vecs[11] = '{c_ROL,  4'b0000, 1'b1, 1'b0, 4'b0110, 1'b0};
        vecs[12] = '{c_ROL,  4'b0000, 1'b0, 1'b1, 4'b1100, 1'b0};
        vecs[13] = '{c_ROL,  4'b0000, 1'b1, 1'b1, 4'b1001, 1'b0};
        vecs[14] = '{c_ROL,  4'b0000, 1'b0, 1'b0, 4'b0011, 1'b0};
        vecs[15] = '{c_LOAD, 4'b1110, 1'b0, 1'b0, 4'b1110, 1'b0};
        vecs[16] = '{c_INC,  4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0};
        vecs[17] = '{c_INC,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1};
        vecs[18] = '{c_INC,  4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0};
        vecs[19] = '{c_DEC,  4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0};
        vecs[20] = '{c_DEC,  4'b0000, 1'b1, 1'b1, 4'b1111, 1'b1};
        vecs[21] = '{c_HOLD, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0};

        // Asynchronous reset asserted between edges, then held across edges with LOAD 0.
        rst = 1'b0; mode = c_HOLD; d = 4'd0; sin_lsb = 1'b0; sin_msb = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_state("reset_async", c_RVAL, 1'b0);
        mode = c_LOAD; d = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset_held_load", c_RVAL, 1'b0);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            apply(vecs[i].mode, vecs[i].d, vecs[i].sl, vecs[i].sm);
            check_state($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_wrap);
        end

        // Reset clears a pending wrap pulse without a clock edge.
        apply(c_INC, 4'd0, 1'b0, 1'b0);
        check_state("wrap_before_reset", 4'b0000, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_state("wrap_cleared_by_reset", c_RVAL, 1'b0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Count up from zero and reset asynchronously at 0101.
        apply(c_LOAD, 4'b0000, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) apply(c_INC, 4'd0, 1'b0, 1'b0);
        check_state("count_to_5", 4'b0101, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_state("midcount_reset", c_RVAL, 1'b0);
        #2;
        rst = 1'b0;
        apply(c_INC, 4'd0, 1'b0, 1'b0);
        check_state("inc_after_reset", c_RVAL + 4'd1, 1'b0);

        // Randomized traffic against an arithmetic reference model.
        m = int'(c_RVAL) + 1;
        for (int i = 0; i < 400; i++) begin
            rmode = 3'($urandom_range(0, 7));
            rd    = 4'($urandom);
            rsl   = 1'($urandom);
            rsm   = 1'($urandom);
            case (rmode)
                c_HOLD:  nm = m;
                c_LOAD:  nm = int'(rd);
                c_SHL:   nm = (m * 2 + int'(rsl)) % 16;
                c_SHR:   nm = m / 2 + int'(rsm) * 8;
                c_ROL:   nm = (m * 2) % 16 + m / 8;
                c_ROR:   nm = m / 2 + (m % 2) * 8;
                c_INC:   nm = (m + 1) % 16;
                default: nm = (m + 15) % 16;
            endcase
            mw = (rmode == c_INC && m == 15) || (rmode == c_DEC && m == 0);
            apply(rmode, rd, rsl, rsm);
            m = nm;
            check_state($sformatf("rand%0d_mode%0d", i, rmode), 4'(m), mw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
